bf_io: RTL and testbench

- Console I/O unit directly downstream and upstream of the bf core's I/O port.
- Buffers bytes emitted by "." (io_wr/io_dout) into a TX FIFO drained by a host-side valid/ready stream.
- Buffers host-supplied bytes into an RX FIFO that presents io_din to the core for ",", with io_in_ready/io_in_ack handshake.
- Provides full/empty status so the core can stall instead of losing data.

---
 rtl/bf_io.sv | 122 ++++++++++++
 tb/tb_bf_io.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bf_io.sv
// Console I/O unit for the bf core: a TX FIFO carries "." bytes out to the host,
// and an RX FIFO carries host bytes in for ",". Both FIFOs are first-word-fall-through.
module bf_io #(
    parameter int DATA_WIDTH = 8,
    parameter int TX_AW      = 3,
    parameter int RX_AW      = 3
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  io_wr,
    input  logic [DATA_WIDTH-1:0] io_dout,
    output logic                  io_out_full,
    output logic [DATA_WIDTH-1:0] io_din,
    output logic                  io_in_ready,
    input  logic                  io_in_ack,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    output logic [TX_AW:0]        tx_count,
    output logic [RX_AW:0]        rx_count,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int TX_DEPTH = 1 << TX_AW;
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam logic [TX_AW:0] TX_FULL_CNT = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_FULL_CNT = {1'b1, {RX_AW{1'b0}}};

    logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
    logic             err_ov_q, err_ov_d;
    logic             err_un_q, err_un_d;

    logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];

    logic tx_full, rx_full, tx_push, tx_pop, rx_push, rx_pop;

    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign tx_valid    = (tx_cnt_q != '0);
    assign io_in_ready = (rx_cnt_q != '0);
    assign io_out_full = tx_full;
    assign rx_ready    = !rx_full;

    assign tx_push = io_wr & !tx_full;
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = io_in_ack & io_in_ready;

    assign tx_data       = tx_mem_q[tx_rp_q];
    assign io_din        = rx_mem_q[rx_rp_q];
    assign tx_count      = tx_cnt_q;
    assign rx_count      = rx_cnt_q;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        err_ov_d = err_ov_q | (io_wr & tx_full);
        err_un_d = err_un_q | (io_in_ack & !io_in_ready);

        if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetq) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            err_ov_q <= err_ov_d;
            err_un_q <= err_un_d;
        end
    end

    // NOTE: storage is not reset; counts gate visibility, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (resetq && tx_push) tx_mem_q[tx_wp_q] <= io_dout;
        if (resetq && rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    end

endmodule

// File: tb/tb_bf_io.sv
// Directed bench for bf_io: TX/RX FIFO ordering, full/empty boundaries, sticky errors, reset.
module tb_bf_io;

    logic       clk = 1'b0;
    logic       resetq = 1'b1;
    logic       io_wr = 1'b0;
    logic [7:0] io_dout = '0;
    logic       io_out_full;
    logic [7:0] io_din;
    logic       io_in_ready;
    logic       io_in_ack = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ready;
    logic [3:0] tx_count;
    logic [3:0] rx_count;
    logic       err_overflow;
    logic       err_underflow;

    int total = 0;
    int bad   = 0;

    bf_io #(.DATA_WIDTH(8), .TX_AW(3), .RX_AW(3)) dut (
        .clk(clk), .resetq(resetq),
        .io_wr(io_wr), .io_dout(io_dout), .io_out_full(io_out_full),
        .io_din(io_din), .io_in_ready(io_in_ready), .io_in_ack(io_in_ack),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetq = 1'b0;
        step();
        step();
        resetq = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        total++; if (io_in_ready !== 1'b0) begin bad++; $display("FAIL reset_io_in_ready got=%0b exp=0", io_in_ready); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%0b exp=1", rx_ready); end
        total++; if (io_out_full !== 1'b0) begin bad++; $display("FAIL reset_io_out_full got=%0b exp=0", io_out_full); end
        total++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin bad++; $display("FAIL reset_counts got tx=%0d rx=%0d exp=0", tx_count, rx_count); end
        total++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin bad++; $display("FAIL reset_errs got ov=%0b un=%0b exp=0", err_overflow, err_underflow); end
    endtask

    task automatic test_tx_basic();
        io_wr = 1'b1; io_dout = 8'h48;
        step();
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin bad++; $display("FAIL tx_latency got v=%0b d=%h exp v=1 d=48", tx_valid, tx_data); end
        io_dout = 8'h69;
        step();
        io_wr = 1'b0;
        total++; if (tx_count !== 4'd2) begin bad++; $display("FAIL tx_count2 got=%0d exp=2", tx_count); end
        total++; if (tx_data !== 8'h48) begin bad++; $display("FAIL tx_head got=%h exp=48", tx_data); end
        tx_ready = 1'b1;
        step();
        total++; if (tx_data !== 8'h69 || tx_count !== 4'd1) begin bad++; $display("FAIL tx_second got d=%h c=%0d exp d=69 c=1", tx_data, tx_count); end
        step();
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0 || tx_count !== 4'd0) begin bad++; $display("FAIL tx_drained got v=%0b c=%0d exp v=0 c=0", tx_valid, tx_count); end
    endtask

    // Pointers start at 2 here, so the 8-entry fill and drain both wrap.
    task automatic test_tx_overflow();
        for (int i = 1; i <= 9; i++) begin
            io_wr = 1'b1; io_dout = 8'(i);
            step();
            if (i == 7) begin
                total++; if (io_out_full !== 1'b0) begin bad++; $display("FAIL tx_not_full_at7 got=%0b exp=0", io_out_full); end
            end
            if (i == 8) begin
                total++; if (io_out_full !== 1'b1 || err_overflow !== 1'b0) begin bad++; $display("FAIL tx_full_at8 got full=%0b ov=%0b exp full=1 ov=0", io_out_full, err_overflow); end
            end
        end
        io_wr = 1'b0;
        total++; if (err_overflow !== 1'b1 || tx_count !== 4'd8) begin bad++; $display("FAIL tx_overflow got ov=%0b c=%0d exp ov=1 c=8", err_overflow, tx_count); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (tx_data !== 8'(i) || tx_valid !== 1'b1) begin bad++; $display("FAIL tx_drain_%0d got v=%0b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(i)); end
            step();
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0 || tx_count !== 4'd0) begin bad++; $display("FAIL tx_after_drain got v=%0b c=%0d exp v=0 c=0", tx_valid, tx_count); end
    endtask

    task automatic test_tx_full_pushpop();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            io_wr = 1'b1; io_dout = 8'h10 + 8'(i);
            step();
        end
        total++; if (io_out_full !== 1'b1 || err_overflow !== 1'b0) begin bad++; $display("FAIL tx_refill got full=%0b ov=%0b exp full=1 ov=0", io_out_full, err_overflow); end
        io_dout = 8'hAA; tx_ready = 1'b1;
        step();
        io_wr = 1'b0; tx_ready = 1'b0;
        total++; if (tx_count !== 4'd7 || err_overflow !== 1'b1) begin bad++; $display("FAIL tx_full_pushpop got c=%0d ov=%0b exp c=7 ov=1", tx_count, err_overflow); end
        total++; if (tx_data !== 8'h11) begin bad++; $display("FAIL tx_full_pushpop_head got=%h exp=11", tx_data); end
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            total++; if (tx_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL tx_nodrop_%0d got=%h exp=%h", i, tx_data, 8'h10 + 8'(i)); end
            step();
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_aa_dropped got v=%0b d=%h exp v=0", tx_valid, tx_data); end
    endtask

    task automatic test_rx_basic();
        rx_valid = 1'b1; rx_data = 8'h41;
        step();
        rx_valid = 1'b0;
        total++; if (io_in_ready !== 1'b1 || io_din !== 8'h41 || rx_count !== 4'd1) begin bad++; $display("FAIL rx_first got r=%0b d=%h c=%0d exp r=1 d=41 c=1", io_in_ready, io_din, rx_count); end
        rx_valid = 1'b1; rx_data = 8'h42; io_in_ack = 1'b1;
        step();
        rx_valid = 1'b0;
        total++; if (rx_count !== 4'd1 || io_din !== 8'h42) begin bad++; $display("FAIL rx_pushpop got c=%0d d=%h exp c=1 d=42", rx_count, io_din); end
        step();
        io_in_ack = 1'b0;
        total++; if (rx_count !== 4'd0 || io_in_ready !== 1'b0 || err_underflow !== 1'b0) begin bad++; $display("FAIL rx_pop got c=%0d r=%0b un=%0b exp c=0 r=0 un=0", rx_count, io_in_ready, err_underflow); end
        io_in_ack = 1'b1;
        step();
        io_in_ack = 1'b0;
        total++; if (err_underflow !== 1'b1 || rx_count !== 4'd0) begin bad++; $display("FAIL rx_underflow got un=%0b c=%0d exp un=1 c=0", err_underflow, rx_count); end
    endtask

    task automatic test_rx_full_reset();
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1; rx_data = 8'h30 + 8'(i);
            step();
        end
        rx_data = 8'h55;
        total++; if (rx_ready !== 1'b0 || rx_count !== 4'd8) begin bad++; $display("FAIL rx_full got rdy=%0b c=%0d exp rdy=0 c=8", rx_ready, rx_count); end
        step();
        total++; if (rx_count !== 4'd8 || io_din !== 8'h30) begin bad++; $display("FAIL rx_refused got c=%0d d=%h exp c=8 d=30", rx_count, io_din); end
        io_in_ack = 1'b1;
        step();
        io_in_ack = 1'b0;
        total++; if (rx_count !== 4'd7 || rx_ready !== 1'b1 || io_din !== 8'h31) begin bad++; $display("FAIL rx_full_pop got c=%0d rdy=%0b d=%h exp c=7 rdy=1 d=31", rx_count, rx_ready, io_din); end
        step();
        rx_valid = 1'b0;
        total++; if (rx_count !== 4'd8) begin bad++; $display("FAIL rx_55_accepted got c=%0d exp=8", rx_count); end
        io_in_ack = 1'b1;
        for (int i = 1; i < 8; i++) step();
        io_in_ack = 1'b0;
        total++; if (io_din !== 8'h55 || rx_count !== 4'd1) begin bad++; $display("FAIL rx_55_order got d=%h c=%0d exp d=55 c=1", io_din, rx_count); end
        io_wr = 1'b1; io_dout = 8'h77;
        step();
        total++; if (tx_count !== 4'd1) begin bad++; $display("FAIL tx_before_reset got c=%0d exp=1", tx_count); end
        resetq = 1'b0; rx_valid = 1'b1;
        step();
        io_wr = 1'b0; rx_valid = 1'b0; resetq = 1'b1;
        total++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin bad++; $display("FAIL midreset_counts got tx=%0d rx=%0d exp 0", tx_count, rx_count); end
        total++; if (tx_valid !== 1'b0 || io_in_ready !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL midreset_status got tv=%0b ir=%0b rr=%0b exp 0 0 1", tx_valid, io_in_ready, rx_ready); end
        total++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin bad++; $display("FAIL midreset_errs got ov=%0b un=%0b exp 0 0", err_overflow, err_underflow); end
    endtask

    initial begin
        step();
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_tx_full_pushpop();
        test_rx_basic();
        test_rx_full_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
